// File: rtl/irq_controller_if.sv
//==============================================================================
// Module   : irq_controller_if
// Brief    : Signal bundle between the interrupt controller and its environment.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface irq_controller_if #(
   parameter int N_IRQ = 8,
   parameter int ID_W  = 3
);
   logic [N_IRQ-1:0] irq_in;
   logic             mask_we;
   logic [N_IRQ-1:0] mask_data;
   logic             int_ack;
   logic             int_eoi;
   logic             int_req;
   logic [ID_W-1:0]  int_id;
   logic [15:0]      int_vector;
   logic [N_IRQ-1:0] pending;
   logic [N_IRQ-1:0] in_service;
   logic [N_IRQ-1:0] mask;

   // master: the controller itself; slave: the sources and CPU around it
   modport master (
      input  irq_in, mask_we, mask_data, int_ack, int_eoi,
      output int_req, int_id, int_vector, pending, in_service, mask
   );

   modport slave (
      output irq_in, mask_we, mask_data, int_ack, int_eoi,
      input  int_req, int_id, int_vector, pending, in_service, mask
   );
endinterface

`default_nettype wire

// File: rtl/irq_controller.sv
//==============================================================================
// Module   : irq_controller
// Brief    : Edge-latching, maskable, fixed-priority interrupt controller with
//            request/acknowledge/end-of-interrupt handshake towards the CPU.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module irq_controller #(
   parameter int          N_IRQ         = 8,
   parameter int          ID_W          = 3,
   parameter logic [15:0] VECTOR_BASE   = 16'h0300,
   parameter int          VECTOR_STRIDE = 4
) (
   input wire logic         clk,
   input wire logic         reset,
   irq_controller_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQUEST = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   logic [N_IRQ-1:0] r_irq_prev;
   logic [N_IRQ-1:0] r_pending;
   logic [N_IRQ-1:0] r_in_service;
   logic [N_IRQ-1:0] r_mask;
   logic             r_int_req;
   logic [ID_W-1:0]  r_int_id;

   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_eligible;
   logic [N_IRQ-1:0] w_id_onehot;
   logic [N_IRQ-1:0] w_ack_clr;
   logic             w_ack_take;
   logic [ID_W-1:0]  w_sel;

   assign w_rise      = bus.irq_in & ~r_irq_prev;
   assign w_eligible  = r_pending & r_mask;
   assign w_id_onehot = N_IRQ'(1) << r_int_id;
   assign w_ack_take  = (r_state == ST_REQUEST) && bus.int_ack;
   assign w_ack_clr   = w_ack_take ? w_id_onehot : '0;

   // Descending scan so the lowest set index is the last one written
   always_comb begin
      w_sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_sel = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_irq_prev   <= '0;
         r_pending    <= '0;
         r_in_service <= '0;
         r_mask       <= '0;
         r_int_req    <= 1'b0;
         r_int_id     <= '0;
      end else begin
         r_irq_prev <= bus.irq_in;
         // A new edge on the line being acknowledged keeps it pending
         r_pending  <= (r_pending & ~w_ack_clr) | w_rise;
         if (bus.mask_we) begin
            r_mask <= bus.mask_data;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_eligible != '0) begin
                  r_int_id  <= w_sel;
                  r_int_req <= 1'b1;
                  r_state   <= ST_REQUEST;
               end
            end
            ST_REQUEST: begin
               if (bus.int_ack) begin
                  r_in_service <= w_id_onehot;
                  r_int_req    <= 1'b0;
                  r_state      <= ST_SERVICE;
               end else if (!r_mask[r_int_id]) begin
                  r_int_req <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_SERVICE: begin
               if (bus.int_eoi) begin
                  r_in_service <= '0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_int_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.int_req    = r_int_req;
   assign bus.int_id     = r_int_id;
   assign bus.int_vector = VECTOR_BASE + 16'(r_int_id) * 16'(VECTOR_STRIDE);
   assign bus.pending    = r_pending;
   assign bus.in_service = r_in_service;
   assign bus.mask       = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
//==============================================================================
// Module   : tb_irq_controller
// Brief    : Directed and randomized checks of irq_controller against a
//            line-level behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_irq_controller;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   irq_controller_if #(.N_IRQ(8), .ID_W(3)) bus ();

   irq_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: which line is presented / in service (-1 = none)
   logic [7:0] m_pending;
   logic [7:0] m_mask;
   logic [7:0] m_prev;
   int         m_req_line;
   int         m_svc_line;
   int         m_id;

   task automatic model_reset();
      m_pending  = '0;
      m_mask     = '0;
      m_prev     = '0;
      m_req_line = -1;
      m_svc_line = -1;
      m_id       = 0;
   endtask

   task automatic model_edge();
      logic [7:0] rise;
      logic [7:0] elig;
      rise = bus.irq_in & ~m_prev;
      elig = m_pending & m_mask;
      if (m_req_line >= 0) begin
         if (bus.int_ack) begin
            m_pending[m_req_line] = 1'b0;
            m_svc_line = m_req_line;
            m_req_line = -1;
         end else if (!m_mask[m_req_line]) begin
            m_req_line = -1;
         end
      end else if (m_svc_line >= 0) begin
         if (bus.int_eoi) m_svc_line = -1;
      end else if (elig != 0) begin
         for (int k = 7; k >= 0; k--) if (elig[k]) m_req_line = k;
         m_id = m_req_line;
      end
      m_pending = m_pending | rise;
      if (bus.mask_we) m_mask = bus.mask_data;
      m_prev = bus.irq_in;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] svc;
      svc = (m_svc_line >= 0) ? (8'd1 << m_svc_line) : 8'd0;
      check("int_req",    32'(bus.int_req),    32'(m_req_line >= 0));
      check("int_id",     32'(bus.int_id),     32'(m_id));
      check("int_vector", 32'(bus.int_vector), 32'(16'h0300 + m_id * 4));
      check("pending",    32'(bus.pending),    32'(m_pending));
      check("in_service", 32'(bus.in_service), 32'(svc));
      check("mask",       32'(bus.mask),       32'(m_mask));
   endtask

   // One clock: model follows the edge, outputs checked 1 time unit later
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      bus.irq_in    = '0;
      bus.mask_we   = 1'b0;
      bus.mask_data = '0;
      bus.int_ack   = 1'b0;
      bus.int_eoi   = 1'b0;
   endtask

   task automatic write_mask(input logic [7:0] v);
      bus.mask_we = 1'b1; bus.mask_data = v; tick();
      bus.mask_we = 1'b0;
   endtask

   task automatic ack();
      bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
   endtask

   task automatic eoi();
      bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      model_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_all();

      // Single request on line 5
      write_mask(8'hFF);
      bus.irq_in = 8'h20; tick();
      check("t1_pending", 32'(bus.pending), 32'h20);
      bus.irq_in = 8'h00; tick();
      check("t1_req", 32'(bus.int_req), 32'd1);
      check("t1_vec", 32'(bus.int_vector), 32'h0314);
      ack();
      check("t1_svc", 32'(bus.in_service), 32'h20);
      eoi();

      // Priority: lines 6 and 2 together
      bus.irq_in = 8'h44; tick();
      bus.irq_in = 8'h00; tick();
      check("t2_first_vec", 32'(bus.int_vector), 32'h0308);
      ack(); eoi(); tick();
      check("t2_second_vec", 32'(bus.int_vector), 32'h0318);
      ack(); eoi();

      // Masked line stays pending until enabled
      write_mask(8'h00);
      bus.irq_in = 8'h08; tick();
      bus.irq_in = 8'h00; tick(); tick();
      check("t3_no_req", 32'(bus.int_req), 32'd0);
      write_mask(8'h08);
      tick();
      check("t3_req_id", 32'(bus.int_id), 32'd3);
      ack(); eoi();

      // Withdraw on mask clear; held level counts once
      write_mask(8'hFF);
      bus.irq_in = 8'h10; tick();
      bus.irq_in = 8'h00; tick();
      write_mask(8'h00);
      tick();
      check("t4_withdraw", 32'(bus.int_req), 32'd0);
      bus.irq_in = 8'h02;
      repeat (20) tick();
      check("t4_pending", 32'(bus.pending), 32'h12);
      bus.irq_in = 8'h00;
      write_mask(8'hFF);
      tick(); ack(); eoi(); tick(); ack(); eoi();

      // New edge coinciding with ack, then reset while in service
      bus.irq_in = 8'h01; tick();
      bus.irq_in = 8'h00; tick();
      bus.irq_in = 8'h01; ack();
      check("t5_set_wins", 32'(bus.pending), 32'h01);
      bus.irq_in = 8'h00;
      eoi(); tick();
      check("t5_rereq", 32'(bus.int_req), 32'd1);
      ack();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("t5_no_req", 32'(bus.int_req), 32'd0);

      // Randomized traffic, including ack/eoi outside their states
      write_mask(8'hFF);
      for (int c = 0; c < 400; c++) begin
         bus.irq_in    = bus.irq_in ^ (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
         bus.mask_we   = ($urandom_range(0, 9) == 0);
         bus.mask_data = 8'($urandom) | 8'h81;
         bus.int_ack   = ($urandom_range(0, 2) == 0);
         bus.int_eoi   = ($urandom_range(0, 2) == 0);
         tick();
      end
      idle_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
